mult_div_unit: RTL

- Multi-cycle multiply/divide sequencer for the E stage, alongside the single-cycle ALU.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU for a fixed number of cycles, asserting busy throughout.
- Services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO reads.
- The hazard unit stalls D-stage md-class instructions while start or busy is high.

---
 rtl/mult_div_unit_pkg.sv | 24 ++
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mdu_arith.sv | 56 +++++
 rtl/mult_div_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - MDU op encodings, default latencies and FSM state encodings
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;
    localparam int CNT_W               = 16;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - E-stage issue and HI/LO readback bundle for the MDU
interface mult_div_unit_if;

    logic        E_MDU_Start;
    logic [2:0]  E_MDU_Op;
    logic [31:0] E_MDU_A;
    logic [31:0] E_MDU_B;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_HI;
    logic [31:0] E_MDU_LO;

    modport master (
        output E_MDU_Start, E_MDU_Op, E_MDU_A, E_MDU_B,
        input  E_MDU_Busy, E_MDU_HI, E_MDU_LO
    );

    modport slave (
        input  E_MDU_Start, E_MDU_Op, E_MDU_A, E_MDU_B,
        output E_MDU_Busy, E_MDU_HI, E_MDU_LO
    );

endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] a_zx;
    logic        [63:0] b_zx;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic               div_ovf;

    assign a_sx = {{32{a[31]}}, a};
    assign b_sx = {{32{b[31]}}, b};
    assign a_zx = {32'h0, a};
    assign b_zx = {32'h0, b};
    assign a_s  = a;
    assign b_s  = b;

    // Most-negative / -1 overflows the signed quotient; the defined result is the dividend with zero remainder.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT:  result = a_sx * b_sx;
            MDU_MULTU: result = a_zx * b_zx;
            MDU_DIV: begin
                if (b == 32'h0) begin
                    div_by_zero = 1'b1;
                end else if (div_ovf) begin
                    result = {32'h0, a};
                end else begin
                    result = {32'(a_s % b_s), 32'(a_s / b_s)};
                end
            end
            MDU_DIVU: begin
                if (b == 32'h0) begin
                    div_by_zero = 1'b1;
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/DIV sequencer owning the HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   mdu
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_dbz_q, pend_dbz_d;

    logic [63:0]      arith_result;
    logic             arith_dbz;

    mdu_arith u_arith (
        .a           (mdu.E_MDU_A),
        .b           (mdu.E_MDU_B),
        .op          (mdu.E_MDU_Op),
        .result      (arith_result),
        .div_by_zero (arith_dbz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_q     <= '0;
            pend_dbz_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_q     <= pend_d;
            pend_dbz_q <= pend_dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_d     = pend_q;
        pend_dbz_d = pend_dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu.E_MDU_Start) begin
                    case (mdu.E_MDU_Op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_d     = arith_result;
                            pend_dbz_d = arith_dbz;
                            cnt_d      = MULT_N;
                            state_d    = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_d     = arith_result;
                            pend_dbz_d = arith_dbz;
                            cnt_d      = DIV_N;
                            state_d    = ST_RUN;
                        end
                        MDU_MTHI: hi_d = mdu.E_MDU_A;
                        MDU_MTLO: lo_d = mdu.E_MDU_A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Start is deliberately not looked at here: a new issue cannot disturb an op in flight.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!pend_dbz_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mdu.E_MDU_Busy = (state_q == ST_RUN);
    assign mdu.E_MDU_HI   = hi_q;
    assign mdu.E_MDU_LO   = lo_q;

endmodule
